// File: rtl/ddr_req_queue.sv
// Request FIFO that paces single-cycle act_cmd strobes into the DDR controller.
// Optional issue/stall counters are enabled with DDR_REQ_STATS_EN.
package ddr_req_pkg;
  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } rw_e;

  typedef struct packed {
    logic [31:0] physical_addr;
    logic [63:0] data_wr;
    rw_e         rw;
  } input_data_type;
endpackage

module ddr_req_queue
  import ddr_req_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int MIN_GAP = 8
) (
  input  logic                     clock_n,
  input  logic                     reset_n,
  input  logic                     req_valid,
  input  input_data_type           req_data,
  output logic                     req_ready,
  input  logic                     dev_busy,
  input  logic                     next_cmd,
  output logic                     act_cmd,
  output input_data_type           data_in,
  output logic [$clog2(DEPTH):0]   q_count
`ifdef DDR_REQ_STATS_EN
  ,
  output logic [15:0]              wr_issued,
  output logic [15:0]              rd_issued,
  output logic [15:0]              full_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(MIN_GAP);
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] P_ONE = AW'(1);
  localparam logic [GW-1:0] G_ONE = GW'(1);
  // ISSUE, WAIT and IDLE each cost one cycle of the loop
  localparam logic [GW-1:0] GAP_LD = GW'(MIN_GAP - 4);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP,
    WAIT
  } state_e;

  state_e         state_q, state_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    cnt_q;
  input_data_type data_q;
  input_data_type mem_q [DEPTH];

  logic push, pop, start;

  assign req_ready = (cnt_q != FULL);
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == ISSUE);
  assign start     = (state_q == IDLE) && (state_d == ISSUE);
  assign act_cmd   = pop;
  assign data_in   = data_q;
  assign q_count   = cnt_q;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (cnt_q != '0 && !dev_busy && next_cmd)
          state_d = ISSUE;
      end
      ISSUE: begin
        state_d = GAP;
        gap_d   = GAP_LD;
      end
      GAP: begin
        if (gap_q == '0) state_d = WAIT;
        else             gap_d   = gap_q - G_ONE;
      end
      WAIT: begin
        if (!dev_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_n) begin
    if (push) mem_q[wr_ptr_q] <= req_data;
  end

  always_ff @(posedge clock_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      if (push) wr_ptr_q <= wr_ptr_q + P_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + P_ONE;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + C_ONE;
        2'b01:   cnt_q <= cnt_q - C_ONE;
        default: cnt_q <= cnt_q;
      endcase
      if (start) data_q <= mem_q[rd_ptr_q];
    end
  end

`ifdef DDR_REQ_STATS_EN
  logic [15:0] wr_q, rd_q, fs_q;

  always_ff @(posedge clock_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      fs_q <= '0;
    end else begin
      if (pop && data_q.rw == WRITE && wr_q != 16'hFFFF)
        wr_q <= wr_q + 16'd1;
      if (pop && data_q.rw == READ && rd_q != 16'hFFFF)
        rd_q <= rd_q + 16'd1;
      if (req_valid && !req_ready && fs_q != 16'hFFFF)
        fs_q <= fs_q + 16'd1;
    end
  end

  assign wr_issued  = wr_q;
  assign rd_issued  = rd_q;
  assign full_stall = fs_q;
`endif

endmodule

// File: tb/tb_ddr_req_queue.sv
// Directed bench for ddr_req_queue: latency, spacing, busy hold, full, reset.
// Stats checks run only when DDR_REQ_STATS_EN is defined.
module tb_ddr_req_queue;
  import ddr_req_pkg::*;

  logic           clock_n = 1'b0;
  logic           reset_n = 1'b0;
  logic           req_valid = 1'b0;
  input_data_type req_data = '0;
  logic           req_ready;
  logic           dev_busy = 1'b0;
  logic           next_cmd = 1'b1;
  logic           act_cmd;
  input_data_type data_in;
  logic [3:0]     q_count;
`ifdef DDR_REQ_STATS_EN
  logic [15:0]    wr_issued, rd_issued, full_stall;
`endif

  int vecs = 0;
  int errs = 0;

  ddr_req_queue dut (
    .clock_n   (clock_n),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .dev_busy  (dev_busy),
    .next_cmd  (next_cmd),
    .act_cmd   (act_cmd),
    .data_in   (data_in),
    .q_count   (q_count)
`ifdef DDR_REQ_STATS_EN
    ,
    .wr_issued (wr_issued),
    .rd_issued (rd_issued),
    .full_stall(full_stall)
`endif
  );

  always #5 clock_n = ~clock_n;

  task automatic tick();
    @(posedge clock_n);
    #1;
  endtask

  function automatic input_data_type mk(input int k, input rw_e rw);
    input_data_type r;
    r.physical_addr = 32'h2000_a000 + 32'(k);
    r.data_wr       = {32'hc0de_0000 + 32'(k), 32'h0000_a000 + 32'(k)};
    r.rw            = rw;
    return r;
  endfunction

  task automatic do_reset();
    req_valid = 1'b0;
    reset_n   = 1'b0;
    tick();
    reset_n   = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    vecs++;
    if (q_count !== 4'd0) begin
      errs++; $display("FAIL rst_count got %0d want 0", q_count);
    end
    vecs++;
    if (act_cmd !== 1'b0) begin
      errs++; $display("FAIL rst_act got %b want 0", act_cmd);
    end
    vecs++;
    if (data_in !== '0) begin
      errs++; $display("FAIL rst_data got %h want 0", data_in);
    end
    vecs++;
    if (req_ready !== 1'b1) begin
      errs++; $display("FAIL rst_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_single_write();
    input_data_type d;
    d.physical_addr = 32'h2000a011;
    d.data_wr       = 64'h0000a0110000a011;
    d.rw            = WRITE;
    dev_busy  = 1'b0;
    next_cmd  = 1'b1;
    req_valid = 1'b1;
    req_data  = d;
    tick();
    req_valid = 1'b0;
    vecs++;
    if (q_count !== 4'd1 || act_cmd !== 1'b0) begin
      errs++;
      $display("FAIL single_c1 got cnt=%0d act=%b want cnt=1 act=0",
               q_count, act_cmd);
    end
    tick();
    vecs++;
    if (act_cmd !== 1'b1 || data_in !== d) begin
      errs++;
      $display("FAIL single_act got act=%b data=%h want act=1 data=%h",
               act_cmd, data_in, d);
    end
    tick();
    vecs++;
    if (act_cmd !== 1'b0 || q_count !== 4'd0 || data_in !== d) begin
      errs++;
      $display("FAIL single_after got act=%b cnt=%0d data=%h want 0 0 %h",
               act_cmd, q_count, data_in, d);
    end
    repeat (12) tick();
  endtask

  task automatic test_back_to_back();
    int pi[$];
    input_data_type pd[$];
    input_data_type v[3];
    v[0] = mk(1, WRITE);
    v[1] = mk(2, READ);
    v[2] = mk(3, WRITE);
    for (int i = 0; i < 40; i++) begin
      req_valid = (i < 3);
      req_data  = (i < 3) ? v[i] : '0;
      tick();
      if (act_cmd) begin
        pi.push_back(i);
        pd.push_back(data_in);
      end
    end
    req_valid = 1'b0;
    vecs++;
    if (pi.size() != 3) begin
      errs++; $display("FAIL b2b_pulses got %0d want 3", pi.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (pi[k] != 1 + 8 * k || pd[k] !== v[k]) begin
          errs++;
          $display("FAIL b2b_%0d got cyc=%0d data=%h want cyc=%0d data=%h",
                   k, pi[k], pd[k], 1 + 8 * k, v[k]);
        end
      end
    end
    vecs++;
    if (q_count !== 4'd0) begin
      errs++; $display("FAIL b2b_empty got %0d want 0", q_count);
    end
  endtask

  task automatic test_busy_hold();
    int pi[$];
    input_data_type pd[$];
    input_data_type v[2];
    v[0] = mk(10, READ);
    v[1] = mk(11, WRITE);
    for (int i = 0; i < 40; i++) begin
      req_valid = (i < 2);
      req_data  = (i < 2) ? v[i] : '0;
      dev_busy  = (i >= 2 && i < 22);
      tick();
      if (act_cmd) begin
        pi.push_back(i);
        pd.push_back(data_in);
      end
    end
    req_valid = 1'b0;
    dev_busy  = 1'b0;
    vecs++;
    if (pi.size() != 2) begin
      errs++; $display("FAIL busy_pulses got %0d want 2", pi.size());
    end else begin
      vecs++;
      if (pi[0] != 1 || pd[0] !== v[0]) begin
        errs++;
        $display("FAIL busy_first got cyc=%0d want 1", pi[0]);
      end
      vecs++;
      if (pi[1] != 23 || pd[1] !== v[1]) begin
        errs++;
        $display("FAIL busy_second got cyc=%0d data=%h want 23 %h",
                 pi[1], pd[1], v[1]);
      end
    end
  endtask

  task automatic test_full();
    input_data_type e[9];
    int n;
    for (int k = 0; k < 9; k++) e[k] = mk(20 + k, (k % 2) ? READ : WRITE);
    next_cmd = 1'b0;
    for (int k = 0; k < 8; k++) begin
      req_valid = 1'b1;
      req_data  = e[k];
      tick();
    end
    req_data = e[8];
    vecs++;
    if (q_count !== 4'd8 || req_ready !== 1'b0) begin
      errs++;
      $display("FAIL full_8 got cnt=%0d rdy=%b want 8 0", q_count, req_ready);
    end
    repeat (3) tick();
    vecs++;
    if (q_count !== 4'd8 || req_ready !== 1'b0) begin
      errs++;
      $display("FAIL full_hold got cnt=%0d rdy=%b want 8 0",
               q_count, req_ready);
    end
    next_cmd = 1'b1;
    tick();
    vecs++;
    if (act_cmd !== 1'b1 || data_in !== e[0] || q_count !== 4'd8) begin
      errs++;
      $display("FAIL full_issue got act=%b cnt=%0d data=%h want 1 8 %h",
               act_cmd, q_count, data_in, e[0]);
    end
    tick();
    vecs++;
    if (q_count !== 4'd7 || req_ready !== 1'b1) begin
      errs++;
      $display("FAIL full_pop got cnt=%0d rdy=%b want 7 1",
               q_count, req_ready);
    end
    tick();
    req_valid = 1'b0;
    vecs++;
    if (q_count !== 4'd8) begin
      errs++; $display("FAIL full_ninth got cnt=%0d want 8", q_count);
    end
    n = 1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (act_cmd) begin
        vecs++;
        if (n > 8 || data_in !== e[n > 8 ? 8 : n]) begin
          errs++;
          $display("FAIL full_order_%0d got %h", n, data_in);
        end
        n++;
      end
    end
    vecs++;
    if (n != 9 || q_count !== 4'd0) begin
      errs++;
      $display("FAIL full_drain got issued=%0d cnt=%0d want 9 0",
               n, q_count);
    end
  endtask

  task automatic test_reset_midop();
    int acts;
    input_data_type z;
    dev_busy = 1'b0;
    next_cmd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_data  = mk(40 + i, WRITE);
      tick();
    end
    req_valid = 1'b0;
    reset_n   = 1'b0;
    tick();
    reset_n   = 1'b1;
    vecs++;
    if (q_count !== 4'd0 || act_cmd !== 1'b0 || data_in !== '0) begin
      errs++;
      $display("FAIL midrst got cnt=%0d act=%b data=%h want 0 0 0",
               q_count, act_cmd, data_in);
    end
    acts = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (act_cmd) acts++;
    end
    vecs++;
    if (acts != 0) begin
      errs++; $display("FAIL midrst_quiet got %0d acts want 0", acts);
    end
    z = mk(50, READ);
    req_valid = 1'b1;
    req_data  = z;
    tick();
    req_valid = 1'b0;
    tick();
    vecs++;
    if (act_cmd !== 1'b1 || data_in !== z) begin
      errs++;
      $display("FAIL midrst_new got act=%b data=%h want 1 %h",
               act_cmd, data_in, z);
    end
    repeat (12) tick();
  endtask

`ifdef DDR_REQ_STATS_EN
  task automatic test_stats();
    do_reset();
    vecs++;
    if (wr_issued !== 16'd0 || rd_issued !== 16'd0 || full_stall !== 16'd0)
    begin
      errs++; $display("FAIL stats_rst got nonzero counters");
    end
    next_cmd = 1'b1;
    for (int i = 0; i < 30; i++) begin
      req_valid = (i < 3);
      req_data  = mk(60 + i, (i == 1) ? READ : WRITE);
      tick();
    end
    next_cmd = 1'b0;
    for (int i = 0; i < 11; i++) begin
      req_valid = 1'b1;
      req_data  = mk(70 + i, WRITE);
      tick();
    end
    req_valid = 1'b0;
    vecs++;
    if (wr_issued !== 16'd2 || rd_issued !== 16'd1 || full_stall !== 16'd3)
    begin
      errs++;
      $display("FAIL stats got wr=%0d rd=%0d stall=%0d want 2 1 3",
               wr_issued, rd_issued, full_stall);
    end
    next_cmd = 1'b1;
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_busy_hold();
    test_full();
    test_reset_midop();
`ifdef DDR_REQ_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
